// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a power-of-two byte FIFO, paced by an external baud_tick.
// Optional even parity bit: define UART_TX_PARITY_EN.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_ready,
  output logic       txd,
  output logic       o_busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          full, push, pop;

  assign full    = (count == FIFO_DEPTH[AW:0]);
  assign o_ready = !full;
  assign push    = i_data_valid && !full;
  // Head is only consumed at a frame boundary, so the in-flight byte is stable.
  assign pop     = baud_tick && (count != '0) && ((state == IDLE) || (state == STOP));
  assign o_busy  = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= mem[rptr];
            txd     <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end else begin
            txd <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            txd   <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= shreg[bit_cnt + 3'd1];
            end else begin
`ifdef UART_TX_PARITY_EN
              txd   <= ^shreg;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (pop) begin
            shreg   <= mem[rptr];
            txd     <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end else if (baud_tick) begin
            txd   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench: a byte FIFO + bit-queue scoreboard predicts txd, o_ready and o_busy each cycle.
module tb_uart_transmitter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       o_ready, txd, o_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifoq[$];
  logic       bitq[$];
  logic       cur_line;
  logic       active;

  uart_transmitter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .i_data(i_data),
    .i_data_valid(i_data_valid), .o_ready(o_ready), .txd(txd), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    bitq.push_back(1'b0);
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bitq.push_back(^b);
`endif
    bitq.push_back(1'b1);
  endtask

  // One clock: drive at negedge, predict, check outputs at the following negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic t);
    logic exp_ready;
    logic [7:0] b;
    i_data_valid = v;
    i_data       = d;
    baud_tick    = t;
    exp_ready = (fifoq.size() < DEPTH);
    chk("ready", o_ready, exp_ready);
    if (t) begin
      if (bitq.size() == 0) begin
        if (fifoq.size() > 0) begin
          b = fifoq.pop_front();
          push_frame(b);
          active = 1'b1;
        end else begin
          active = 1'b0;
        end
      end
      if (bitq.size() > 0) cur_line = bitq.pop_front();
      else                 cur_line = 1'b1;
    end
    if (v && exp_ready) fifoq.push_back(d);
    @(negedge clk);
    chk("txd", txd, cur_line);
    chk("busy", o_busy, active || (fifoq.size() > 0));
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00, 1'b1);
      for (int j = 1; j < gap; j++) step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic clear_model();
    fifoq.delete();
    bitq.delete();
    active   = 1'b0;
    cur_line = 1'b1;
  endtask

  initial begin
    rst = 1'b1; baud_tick = 1'b0; i_data = 8'h00; i_data_valid = 1'b0;
    clear_model();
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single 0xA5 frame, tick every 16 clocks, plus trailing idle ticks.
    step(1'b1, 8'hA5, 1'b0);
    ticks(13, 16);

    // Fill past full without ticks, then drain four contiguous frames.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    ticks(46, 2);

    // Parity check byte with a single set bit.
    step(1'b1, 8'h01, 1'b0);
    ticks(13, 3);

    // Valid held with a tick every cycle: pushes and pops coincide.
    for (int i = 0; i < 60; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
    ticks(70, 1);

    // Reset during DATA bit 3 of 0x0F with two bytes queued.
    step(1'b1, 8'h0F, 1'b0);
    step(1'b1, 8'h66, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    ticks(5, 3);
    chk("pre_rst_bit3", txd, 1'b1);
    i_data_valid = 1'b0; baud_tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_txd", txd, 1'b1);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_ready", o_ready, 1'b1);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    ticks(25, 2);

    // Push accepted on the very first edge after reset release.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hC3, 1'b0);
    ticks(3, 4);

    // No ticks for 1000 clocks mid-frame: line, state and FIFO hold.
    step(1'b1, 8'h9E, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b0, 8'h00, 1'b0);
    ticks(20, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
